// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer in front of the 512-point FFT pipeline.
//
// It accepts 16-lane I/Q beats on a valid/ready stream and cuts them into frames of
// NPT/LANES beats that occupy consecutive cycles. It drives the core's valid and data
// through one register stage. Frames in flight are limited by a credit count that the
// core's do_en pulse returns. Protocol errors raise sticky flags.
//
// Optional feature: define FFT_CTRL_TIMEOUT_EN to add the watchdog. While frames are
// outstanding it counts cycles, and after TO_CYC cycles without do_en it recovers all
// credits and sets err_timeout. Without the macro, o_err_timeout is tied to 0.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_s_valid/o_s_ready  upstream beat handshake; i_s_last marks the frame's last beat
//   i_s_i, i_s_q         upstream samples, LANES x DW packed, lane 0 in the LSBs
//   o_fft_valid          valid to the FFT core
//   o_fft_din_i/q        data to the FFT core
//   i_fft_do_en          core frame-complete pulse (returns one credit)
//   o_frame_done         registered copy of i_fft_do_en
//   o_inflight           frames issued but not yet returned
//   o_busy               a frame is loading or frames are outstanding
//   i_err_clr            clears all sticky error flags (wins over a same-cycle set)
//   o_err_*              sticky flags: underrun, s_last misplacement, spurious do_en, timeout
module fft_frame_ctrl #(
  parameter int unsigned NPT          = 512,
  parameter int unsigned LANES        = 16,
  parameter int unsigned DW           = 9,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned TO_CYC       = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic                  i_s_last,
  input  logic [LANES*DW-1:0]   i_s_i,
  input  logic [LANES*DW-1:0]   i_s_q,
  output logic                  o_fft_valid,
  output logic [LANES*DW-1:0]   o_fft_din_i,
  output logic [LANES*DW-1:0]   o_fft_din_q,
  input  logic                  i_fft_do_en,
  output logic                  o_frame_done,
  output logic [2:0]            o_inflight,
  output logic                  o_busy,
  input  logic                  i_err_clr,
  output logic                  o_err_underrun,
  output logic                  o_err_last,
  output logic                  o_err_spurious,
  output logic                  o_err_timeout
);

  localparam int unsigned BEATS = NPT / LANES;
  localparam int unsigned BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [2:0]    MAX_INFL  = 3'(MAX_INFLIGHT);

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e                r_state, w_state_d;
  logic [BW-1:0]         r_beat_cnt, w_beat_cnt_d;
  logic [2:0]            r_inflight, w_inflight_d;
  logic                  r_s_ready, w_s_ready_d;
  logic                  r_fft_valid;
  logic [LANES*DW-1:0]   r_din_i, r_din_q;
  logic                  r_frame_done;
  logic                  r_err_underrun, r_err_last, r_err_spurious;

  logic                  w_start, w_beat;
  logic [BW-1:0]         w_beat_idx;
  logic                  w_ret, w_spurious, w_timeout;
  logic                  w_set_underrun, w_set_last;

  // Frame sequencing. Once beat 0 is accepted, the frame runs for exactly BEATS cycles
  // and does not wait for s_valid.
  always_comb begin
    w_state_d    = r_state;
    w_beat_cnt_d = r_beat_cnt;
    w_start      = 1'b0;
    w_beat       = 1'b0;
    w_beat_idx   = '0;
    unique case (r_state)
      StIdle: begin
        if (i_s_valid && r_s_ready) begin
          w_start      = 1'b1;
          w_beat       = 1'b1;
          w_state_d    = StLoad;
          w_beat_cnt_d = BW'(1);
        end
      end
      StLoad: begin
        w_beat     = 1'b1;
        w_beat_idx = r_beat_cnt;
        if (r_beat_cnt == LAST_BEAT) begin
          w_state_d    = StIdle;
          w_beat_cnt_d = '0;
        end else begin
          w_beat_cnt_d = r_beat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_beat_cnt_d = '0;
      end
    endcase
  end

  // Credits. A do_en with nothing outstanding is flagged and does not return a credit.
  assign w_spurious = i_fft_do_en && (r_inflight == 3'd0);
  assign w_ret      = i_fft_do_en && (r_inflight != 3'd0);

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TO_CYC + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TO_CYC - 1);

  logic [WW-1:0] r_wdog;
  logic          r_err_timeout;

  // A do_en in the same cycle restarts the count instead of firing.
  assign w_timeout = (r_inflight != 3'd0) && !i_fft_do_en && (r_wdog == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (r_inflight == 3'd0 || i_fft_do_en || w_timeout) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (i_err_clr) begin
        r_err_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_timeout     = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // A timeout drops every credit. A frame starting in the same cycle still claims one.
  always_comb begin
    w_inflight_d = w_timeout ? 3'd0 : (r_inflight - {2'b00, w_ret});
    w_inflight_d = w_inflight_d + {2'b00, w_start};
  end

  // s_ready is registered from the next state, so it reads 0 while in reset.
  assign w_s_ready_d = (w_state_d == StLoad) || (w_inflight_d < MAX_INFL);

  assign w_set_underrun = (r_state == StLoad) && !i_s_valid;
  assign w_set_last     = w_beat && i_s_valid && (i_s_last != (w_beat_idx == LAST_BEAT));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state        <= StIdle;
      r_beat_cnt     <= '0;
      r_inflight     <= 3'd0;
      r_s_ready      <= 1'b0;
      r_fft_valid    <= 1'b0;
      r_din_i        <= '0;
      r_din_q        <= '0;
      r_frame_done   <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_last     <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_beat_cnt   <= w_beat_cnt_d;
      r_inflight   <= w_inflight_d;
      r_s_ready    <= w_s_ready_d;
      r_fft_valid  <= w_beat;
      r_frame_done <= i_fft_do_en;
      // A bubble beat is sent as zeros. Outside a frame the data holds.
      if (w_beat) begin
        r_din_i <= i_s_valid ? i_s_i : '0;
        r_din_q <= i_s_valid ? i_s_q : '0;
      end
      if (i_err_clr) begin
        r_err_underrun <= 1'b0;
        r_err_last     <= 1'b0;
        r_err_spurious <= 1'b0;
      end else begin
        r_err_underrun <= r_err_underrun | w_set_underrun;
        r_err_last     <= r_err_last | w_set_last;
        r_err_spurious <= r_err_spurious | w_spurious;
      end
    end
  end

  assign o_s_ready      = r_s_ready;
  assign o_fft_valid    = r_fft_valid;
  assign o_fft_din_i    = r_din_i;
  assign o_fft_din_q    = r_din_q;
  assign o_frame_done   = r_frame_done;
  assign o_inflight     = r_inflight;
  assign o_busy         = (r_state == StLoad) || (r_inflight != 3'd0);
  assign o_err_underrun = r_err_underrun;
  assign o_err_last     = r_err_last;
  assign o_err_spurious = r_err_spurious;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed scenarios plus a randomized run
// against a frame-level reference model.
module tb_fft_frame_ctrl;
  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 9;
  localparam int unsigned BEATS = 32;
  localparam int unsigned MAXF  = 2;
  localparam int unsigned LW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, do_en = 1'b0, err_clr = 1'b0;
  logic [LW-1:0] s_i = '0, s_q = '0;
  logic          s_ready, fft_valid, frame_done, busy;
  logic [LW-1:0] din_i, din_q;
  logic [2:0]    inflight;
  logic          e_und, e_last, e_spur, e_to;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: m_pos is the index of the next beat of the open frame
  // (0 when no frame is open).
  int            m_pos, m_infl;
  bit            m_ready, m_valid, m_done, m_eu, m_el, m_es;
  logic [LW-1:0] m_di, m_dq;

  fft_frame_ctrl dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .i_s_last      (s_last),
    .i_s_i         (s_i),
    .i_s_q         (s_q),
    .o_fft_valid   (fft_valid),
    .o_fft_din_i   (din_i),
    .o_fft_din_q   (din_q),
    .i_fft_do_en   (do_en),
    .o_frame_done  (frame_done),
    .o_inflight    (inflight),
    .o_busy        (busy),
    .i_err_clr     (err_clr),
    .o_err_underrun(e_und),
    .o_err_last    (e_last),
    .o_err_spurious(e_spur),
    .o_err_timeout (e_to)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_time_limit: simulation still running, want finished");
    $fatal(1, "time limit");
  end

  function automatic logic [LW-1:0] ramp(input int b, input int off);
    logic [LW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'(b * LANES + l + off);
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_data();
    logic [LW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'($urandom_range(0, 511));
    return r;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_infl = 0; m_ready = 0; m_valid = 0; m_done = 0;
    m_eu = 0; m_el = 0; m_es = 0; m_di = '0; m_dq = '0;
  endtask

  // Drive one cycle, advance the model with what the DUT sees at the edge, and return
  // #1 after the edge.
  task automatic cyc(input bit v, input bit last, input logic [LW-1:0] di,
                     input logic [LW-1:0] dq, input bit de, input bit clr);
    bit start, beat, su, sl, ss;
    int idx;
    s_valid = v; s_last = last; s_i = di; s_q = dq; do_en = de; err_clr = clr;
    @(posedge clk);
    start = (m_pos == 0) && v && m_ready;
    beat  = start || (m_pos != 0);
    idx   = start ? 0 : m_pos;
    su = 0; sl = 0;
    if (beat) begin
      m_valid = 1;
      m_di = v ? di : '0;
      m_dq = v ? dq : '0;
      su = !v;
      sl = v && (last != (idx == BEATS - 1));
      m_pos = (idx == BEATS - 1) ? 0 : idx + 1;
    end else begin
      m_valid = 0;
    end
    ss = de && (m_infl == 0);
    if (de && m_infl > 0) m_infl--;
    if (start) m_infl++;
    if (clr) begin
      m_eu = 0; m_el = 0; m_es = 0;
    end else begin
      m_eu |= su; m_el |= sl; m_es |= ss;
    end
    m_done  = de;
    m_ready = (m_pos != 0) || (m_infl < MAXF);
    #1;
  endtask

  task automatic idle(input bit de, input bit clr);
    cyc(0, 0, '0, '0, de, clr);
  endtask

  task automatic do_reset();
    rstn = 0;
    s_valid = 0; s_last = 0; do_en = 0; err_clr = 0; s_i = '0; s_q = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    idle(0, 0);
  endtask

  task automatic test_reset();
    rstn = 0;
    s_valid = 1; s_last = 1; do_en = 1; err_clr = 0; s_i = '1; s_q = '1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({s_ready, fft_valid, din_i, din_q, frame_done, inflight, busy,
         e_und, e_last, e_spur, e_to} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b v=%b di=%h dq=%h done=%b infl=%0d busy=%b err=%b%b%b%b, want all 0",
               s_ready, fft_valid, din_i, din_q, frame_done, inflight, busy,
               e_und, e_last, e_spur, e_to);
    end
    do_reset();
    n_vec++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: got %b want 1", s_ready);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int b = 0; b < BEATS; b++) begin
      cyc(1, b == BEATS - 1, ramp(b, 0), ramp(b, 100), 0, 0);
      n_vec++;
      if (fft_valid !== 1'b1 || din_i !== ramp(b, 0) || din_q !== ramp(b, 100)) begin
        n_err++;
        $display("FAIL t1_beat%0d: got v=%b di=%h, want v=1 di=%h", b, fft_valid, din_i, ramp(b, 0));
      end
    end
    idle(0, 0);
    n_vec++;
    if (fft_valid !== 1'b0 || inflight !== 3'd1 || busy !== 1'b1 || din_i !== ramp(BEATS - 1, 0)
        || e_last !== 1'b0) begin
      n_err++;
      $display("FAIL t1_after_frame: got v=%b infl=%0d busy=%b hold_ok=%b el=%b, want v=0 infl=1 busy=1 hold_ok=1 el=0",
               fft_valid, inflight, busy, din_i === ramp(BEATS - 1, 0), e_last);
    end
    idle(1, 0);
    n_vec++;
    if (frame_done !== 1'b1 || inflight !== 3'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_do_en: got done=%b infl=%0d busy=%b, want done=1 infl=0 busy=0",
               frame_done, inflight, busy);
    end
    idle(0, 0);
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL t1_done_pulse: got %b want 0", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    do_reset();
    nv = 0;
    for (int b = 0; b < 2 * BEATS; b++) begin
      cyc(1, (b % BEATS) == BEATS - 1, ramp(b, 0), ramp(b, 7), 0, 0);
      if (fft_valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv != 2 * BEATS || s_ready !== 1'b0 || inflight !== 3'd2) begin
      n_err++;
      $display("FAIL t2_two_frames: got valid_cycles=%0d rdy=%b infl=%0d, want 64 0 2", nv, s_ready, inflight);
    end
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, ramp(64, 0), ramp(64, 7), 0, 0);
      if (fft_valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv != 0 || inflight !== 3'd2) begin
      n_err++;
      $display("FAIL t2_stalled: got valid_cycles=%0d infl=%0d, want 0 2", nv, inflight);
    end
    cyc(1, 0, ramp(64, 0), ramp(64, 7), 1, 0);
    n_vec++;
    if (inflight !== 3'd1 || s_ready !== 1'b1 || fft_valid !== 1'b0) begin
      n_err++;
      $display("FAIL t2_credit_back: got infl=%0d rdy=%b v=%b, want 1 1 0", inflight, s_ready, fft_valid);
    end
    for (int b = 0; b < BEATS; b++) begin
      cyc(1, b == BEATS - 1, ramp(b, 200), ramp(b, 300), 0, 0);
      if (b == 0) begin
        n_vec++;
        if (inflight !== 3'd2 || fft_valid !== 1'b1 || din_i !== ramp(0, 200)) begin
          n_err++;
          $display("FAIL t2_frame3_start: got infl=%0d v=%b di=%h, want 2 1 %h",
                   inflight, fft_valid, din_i, ramp(0, 200));
        end
      end
    end
    n_vec++;
    if (e_last !== 1'b0 || e_und !== 1'b0) begin
      n_err++;
      $display("FAIL t2_no_errors: got el=%b eu=%b, want 0 0", e_last, e_und);
    end
  endtask

  task automatic test_bubble();
    int nv;
    do_reset();
    nv = 0;
    for (int b = 0; b < BEATS; b++) begin
      cyc(b != 10, b == BEATS - 1, ramp(b, 1), ramp(b, 2), 0, 0);
      if (fft_valid === 1'b1) nv++;
      if (b == 9) begin
        n_vec++;
        if (e_und !== 1'b0) begin
          n_err++;
          $display("FAIL t3_before_bubble: got eu=%b want 0", e_und);
        end
      end
      if (b == 10) begin
        n_vec++;
        if (fft_valid !== 1'b1 || din_i !== '0 || din_q !== '0 || e_und !== 1'b1) begin
          n_err++;
          $display("FAIL t3_bubble: got v=%b di=%h dq=%h eu=%b, want v=1 zeros eu=1",
                   fft_valid, din_i, din_q, e_und);
        end
      end
    end
    idle(0, 0);
    n_vec++;
    if (nv != BEATS || fft_valid !== 1'b0 || e_last !== 1'b0 || inflight !== 3'd1) begin
      n_err++;
      $display("FAIL t3_frame_len: got valid_cycles=%0d v=%b el=%b infl=%0d, want 32 0 0 1",
               nv, fft_valid, e_last, inflight);
    end
    idle(0, 1);
    n_vec++;
    if (e_und !== 1'b0) begin
      n_err++;
      $display("FAIL t3_clear: got eu=%b want 0", e_und);
    end
  endtask

  task automatic test_slast();
    do_reset();
    for (int b = 0; b < BEATS; b++) begin
      cyc(1, b == 20, ramp(b, 3), ramp(b, 4), 0, 0);
      if (b == 19 || b == 20) begin
        n_vec++;
        if (e_last !== (b == 20)) begin
          n_err++;
          $display("FAIL t4_beat%0d: got el=%b want %0d", b, e_last, b == 20);
        end
      end
    end
    idle(0, 1);
    n_vec++;
    if (e_last !== 1'b0 || inflight !== 3'd1) begin
      n_err++;
      $display("FAIL t4_clear: got el=%b infl=%0d, want 0 1", e_last, inflight);
    end
    for (int b = 0; b < BEATS; b++) begin
      cyc(1, b == BEATS - 1, ramp(b, 5), ramp(b, 6), 0, 0);
      if (b == 0) begin
        n_vec++;
        if (fft_valid !== 1'b1 || din_i !== ramp(0, 5) || inflight !== 3'd2) begin
          n_err++;
          $display("FAIL t4_next_start: got v=%b infl=%0d, want 1 2", fft_valid, inflight);
        end
      end
    end
    n_vec++;
    if (e_last !== 1'b0) begin
      n_err++;
      $display("FAIL t4_clean_frame: got el=%b want 0", e_last);
    end
  endtask

  task automatic test_credit();
    do_reset();
    idle(1, 0);
    n_vec++;
    if (e_spur !== 1'b1 || inflight !== 3'd0 || frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL t5_spurious: got es=%b infl=%0d done=%b, want 1 0 1", e_spur, inflight, frame_done);
    end
    idle(1, 1);
    n_vec++;
    if (e_spur !== 1'b0) begin
      n_err++;
      $display("FAIL t5_clr_priority: got es=%b want 0", e_spur);
    end
    for (int b = 0; b < BEATS; b++) cyc(1, b == BEATS - 1, ramp(b, 8), ramp(b, 9), 0, 0);
    cyc(1, 0, ramp(0, 10), ramp(0, 11), 1, 0);
    n_vec++;
    if (inflight !== 3'd1 || fft_valid !== 1'b1 || e_spur !== 1'b0) begin
      n_err++;
      $display("FAIL t5_start_and_do_en: got infl=%0d v=%b es=%b, want 1 1 0", inflight, fft_valid, e_spur);
    end
    for (int b = 1; b < BEATS; b++) cyc(1, b == BEATS - 1, ramp(b, 10), ramp(b, 11), 0, 0);
    n_vec++;
    if (inflight !== 3'd1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL t5_end: got infl=%0d busy=%b, want 1 1", inflight, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int b = 0; b < 10; b++) cyc(b != 5, 0, ramp(b, 12), ramp(b, 13), 0, 0);
    rstn = 0;
    #1;
    n_vec++;
    if ({s_ready, fft_valid, din_i, din_q, frame_done, inflight, busy,
         e_und, e_last, e_spur, e_to} !== '0) begin
      n_err++;
      $display("FAIL t6_reset_mid_load: got rdy=%b v=%b infl=%0d busy=%b eu=%b, want all 0",
               s_ready, fft_valid, inflight, busy, e_und);
    end
    do_reset();
    cyc(1, 0, ramp(0, 14), ramp(0, 15), 0, 0);
    n_vec++;
    if (fft_valid !== 1'b1 || inflight !== 3'd1 || din_i !== ramp(0, 14)) begin
      n_err++;
      $display("FAIL t6_fresh_start: got v=%b infl=%0d, want 1 1", fft_valid, inflight);
    end
  endtask

`ifdef FFT_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    // Edge k counts clocks after the beat-0 edge (k = 0).
    for (int b = 0; b < BEATS; b++) cyc(1, b == BEATS - 1, ramp(b, 16), ramp(b, 17), 0, 0);
    for (int k = BEATS; k <= 4096; k++) begin
      idle(0, 0);
      if (k == 4095) begin
        n_vec++;
        if (e_to !== 1'b0 || inflight !== 3'd1) begin
          n_err++;
          $display("FAIL t6_timeout_early: got et=%b infl=%0d, want 0 1", e_to, inflight);
        end
      end
    end
    n_vec++;
    if (e_to !== 1'b1 || inflight !== 3'd0 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t6_timeout: got et=%b infl=%0d rdy=%b, want 1 0 1", e_to, inflight, s_ready);
    end
    do_reset();
  endtask
`endif

  task automatic test_random();
    bit v, last, de, clr, start;
    int idx;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v     = ($urandom_range(0, 15) != 0);
      start = (m_pos == 0) && v && m_ready;
      idx   = start ? 0 : m_pos;
      last  = (start || m_pos != 0) && (idx == BEATS - 1);
      if ($urandom_range(0, 40) == 0) last = !last;
      de    = (m_infl > 0) && ($urandom_range(0, 24) == 0);
      clr   = ($urandom_range(0, 80) == 0);
      cyc(v, last, rnd_data(), rnd_data(), de, clr);
      n_vec++;
      if ({fft_valid, din_i, din_q, inflight, s_ready, busy, frame_done, e_und, e_last, e_spur}
          !== {m_valid, m_di, m_dq, 3'(m_infl), m_ready, (m_pos != 0) || (m_infl != 0), m_done,
               m_eu, m_el, m_es}) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got v=%b infl=%0d rdy=%b busy=%b done=%b err=%b%b%b di=%h, want v=%b infl=%0d rdy=%b busy=%b done=%b err=%b%b%b di=%h",
                 n, fft_valid, inflight, s_ready, busy, frame_done, e_und, e_last, e_spur, din_i,
                 m_valid, m_infl, m_ready, (m_pos != 0) || (m_infl != 0), m_done, m_eu, m_el, m_es,
                 m_di);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bubble();
    test_slast();
    test_credit();
    test_reset_mid_load();
`ifdef FFT_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
